// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: serial line in, received word and status strobes out.
// master drives SIN, slave is the receiver.
interface serial_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic              SIN;
  logic [DATA_W-1:0] DOUT;
  logic              VALID;
  logic              FERR;
  logic              PERR;
  logic              BUSY;

  modport master (
    output SIN,
    input  DOUT, VALID, FERR, PERR, BUSY
  );

  modport slave (
    input  SIN,
    output DOUT, VALID, FERR, PERR, BUSY
  );
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: framed serial receiver, mid-bit sampling, LSB first.
// Define SERIAL_FRAME_RX_PARITY_EN to expect an even-parity bit before stop.
module serial_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input logic              CLK,
  input logic              RESET,
  serial_frame_rx_if.slave bus
);
  localparam int CW = $clog2(BIT_CYCLES) + 1;
  localparam int IW = $clog2(DATA_W) + 1;

  localparam logic [CW-1:0] HALF = CW'(BIT_CYCLES / 2);
  localparam logic [CW-1:0] FULL = CW'(BIT_CYCLES);
  localparam logic [IW-1:0] LAST = IW'(DATA_W - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_POST      = S_PARITY;
`else
  localparam logic [2:0] S_POST      = S_STOP;
`endif

  logic [2:0]        state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] dout;
  logic [DATA_W:0]   ins;
  logic              valid;
  logic              ferr;
  logic              perr;
  logic              mism;
  logic              expire;

`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic pbit;
  assign mism = ^{sh, pbit};
`else
  assign mism = 1'b0;
`endif

  // bits arrive LSB first, so shifting in from the top lands bit i at i
  assign ins    = {bus.SIN, sh};
  assign expire = (cnt == CW'(1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      dout  <= '0;
      valid <= 1'b0;
      ferr  <= 1'b0;
      perr  <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      pbit  <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      ferr  <= 1'b0;
      perr  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!bus.SIN) begin
            state <= S_START;
            cnt   <= HALF;
          end
        end
        S_START: begin
          if (expire) begin
            state <= bus.SIN ? S_IDLE : S_DATA;
            idx   <= '0;
            cnt   <= FULL;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DATA: begin
          if (expire) begin
            sh  <= ins[DATA_W:1];
            cnt <= FULL;
            if (idx == LAST) state <= S_POST;
            else             idx   <= idx + IW'(1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        S_PARITY: begin
          if (expire) begin
            pbit  <= bus.SIN;
            state <= S_STOP;
            cnt   <= FULL;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (expire) begin
            if (bus.SIN) begin
              state <= S_IDLE;
              if (mism) begin
                perr <= 1'b1;
              end else begin
                dout  <= sh;
                valid <= 1'b1;
              end
            end else begin
              state <= S_WAIT_HIGH;
              ferr  <= 1'b1;
              perr  <= mism;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (bus.SIN) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.DOUT  = dout;
  assign bus.VALID = valid;
  assign bus.FERR  = ferr;
  assign bus.PERR  = perr;
  assign bus.BUSY  = (state != S_IDLE);
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: frame-level stimulus, outputs traced per cycle and
// compared against timing and results derived from the frame contents.
module tb_serial_frame_rx;
  localparam int DW = 8;
  localparam int BC = 4;
  localparam int H  = BC / 2;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int STOP0 = (DW + 1 + P) * BC;
  localparam int KS    = STOP0 + H;
  localparam int MAXC  = 512;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  serial_frame_rx_if #(.DATA_W(DW)) bus ();

  serial_frame_rx #(
    .DATA_W     (DW),
    .BIT_CYCLES (BC)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  bit          line[$];
  logic        ov[MAXC];
  logic        of[MAXC];
  logic        op[MAXC];
  logic        ob[MAXC];
  logic [DW-1:0] od[MAXC];
  int          olen;
  logic [DW-1:0] model_dout;

  // frame image: start, data LSB first, optional parity, stop, idle tail
  task automatic make_frame(input logic [DW-1:0] d, input bit badpar,
                            input bit stopbit, input int stop_len,
                            input int tail);
    repeat (BC) line.push_back(1'b0);
    for (int i = 0; i < DW; i++)
      repeat (BC) line.push_back(d[i]);
    if (P == 1)
      repeat (BC) line.push_back((^d) ^ badpar);
    repeat (stop_len) line.push_back(stopbit);
    repeat (tail) line.push_back(1'b1);
  endtask

  // entry k is seen by the DUT at edge k; outputs traced 1ns after it
  task automatic play(input int n);
    int lim;
    lim  = (n < 0 || n > line.size()) ? line.size() : n;
    olen = 0;
    for (int k = 0; k < lim && k < MAXC; k++) begin
      bus.SIN = line[k];
      @(posedge CLK);
      #1;
      ov[k] = bus.VALID;
      of[k] = bus.FERR;
      op[k] = bus.PERR;
      ob[k] = bus.BUSY;
      od[k] = bus.DOUT;
      olen++;
    end
    line.delete();
    bus.SIN = 1'b1;
  endtask

  function automatic int nstrobe(input bit sv, input bit sf, input bit sp);
    int n;
    n = 0;
    for (int k = 0; k < olen; k++) begin
      if (sv && ov[k] === 1'b1) n++;
      if (sf && of[k] === 1'b1) n++;
      if (sp && op[k] === 1'b1) n++;
    end
    return n;
  endfunction

  task automatic test_reset;
    RESET   = 1'b1;
    bus.SIN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (bus.DOUT !== '0) begin
      errors++; $display("FAIL reset_dout: got %0h want 0", bus.DOUT);
    end
    checks++;
    if (bus.VALID !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", bus.VALID);
    end
    checks++;
    if (bus.FERR !== 1'b0) begin
      errors++; $display("FAIL reset_ferr: got %b want 0", bus.FERR);
    end
    checks++;
    if (bus.PERR !== 1'b0) begin
      errors++; $display("FAIL reset_perr: got %b want 0", bus.PERR);
    end
    checks++;
    if (bus.BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", bus.BUSY);
    end
    RESET = 1'b0;
    model_dout = '0;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_good_frame(input logic [DW-1:0] d);
    make_frame(d, 1'b0, 1'b1, BC, 2);
    play(-1);
    checks++;
    if (ov[KS] !== 1'b1) begin
      errors++; $display("FAIL good_valid_time: got %b want 1", ov[KS]);
    end
    checks++;
    if (od[KS] !== d) begin
      errors++; $display("FAIL good_dout: got %0h want %0h", od[KS], d);
    end
    checks++;
    if (od[KS-1] !== model_dout) begin
      errors++;
      $display("FAIL good_dout_early: got %0h want %0h", od[KS-1], model_dout);
    end
    checks++;
    if (nstrobe(1, 0, 0) !== 1) begin
      errors++;
      $display("FAIL good_valid_count: got %0d want 1", nstrobe(1, 0, 0));
    end
    checks++;
    if (nstrobe(0, 1, 1) !== 0) begin
      errors++;
      $display("FAIL good_err_strobes: got %0d want 0", nstrobe(0, 1, 1));
    end
    checks++;
    if (ob[0] !== 1'b1 || ob[KS-1] !== 1'b1 || ob[KS] !== 1'b0) begin
      errors++;
      $display("FAIL good_busy: got %b%b%b want 110", ob[0], ob[KS-1], ob[KS]);
    end
    model_dout = d;
  endtask

`ifdef SERIAL_FRAME_RX_PARITY_EN
  task automatic test_parity;
    make_frame(8'h3C, 1'b0, 1'b1, BC, 2);
    play(-1);
    checks++;
    if (ov[KS] !== 1'b1 || od[KS] !== 8'h3C) begin
      errors++;
      $display("FAIL par_good: got v=%b d=%0h want v=1 d=3c", ov[KS], od[KS]);
    end
    model_dout = 8'h3C;
    make_frame(8'h3C, 1'b1, 1'b1, BC, 2);
    play(-1);
    checks++;
    if (op[KS] !== 1'b1) begin
      errors++; $display("FAIL par_perr: got %b want 1", op[KS]);
    end
    checks++;
    if (nstrobe(1, 1, 0) !== 0 || nstrobe(0, 0, 1) !== 1) begin
      errors++;
      $display("FAIL par_strobes: got v+f=%0d p=%0d want 0 1",
               nstrobe(1, 1, 0), nstrobe(0, 0, 1));
    end
    checks++;
    if (od[KS] !== model_dout || ob[KS] !== 1'b0) begin
      errors++;
      $display("FAIL par_hold: got d=%0h b=%b want d=%0h b=0",
               od[KS], ob[KS], model_dout);
    end
  endtask
`endif

  task automatic test_false_start;
    line.push_back(1'b0);
    repeat (6) line.push_back(1'b1);
    play(-1);
    checks++;
    if (ob[0] !== 1'b1 || ob[H-1] !== 1'b1 || ob[H] !== 1'b0) begin
      errors++;
      $display("FAIL false_busy: got %b%b%b want 110", ob[0], ob[H-1], ob[H]);
    end
    checks++;
    if (nstrobe(1, 1, 1) !== 0) begin
      errors++;
      $display("FAIL false_strobes: got %0d want 0", nstrobe(1, 1, 1));
    end
    checks++;
    if (od[olen-1] !== model_dout) begin
      errors++;
      $display("FAIL false_dout: got %0h want %0h", od[olen-1], model_dout);
    end
  endtask

  task automatic test_framing;
    int kret;
    kret = STOP0 + BC + 10;
    make_frame(8'h81, 1'b0, 1'b0, BC + 10, 3);
    play(-1);
    checks++;
    if (of[KS] !== 1'b1 || op[KS] !== 1'b0) begin
      errors++;
      $display("FAIL ferr_strobe: got f=%b p=%b want f=1 p=0", of[KS], op[KS]);
    end
    checks++;
    if (nstrobe(1, 0, 0) !== 0 || nstrobe(0, 1, 0) !== 1) begin
      errors++;
      $display("FAIL ferr_counts: got v=%0d f=%0d want 0 1",
               nstrobe(1, 0, 0), nstrobe(0, 1, 0));
    end
    checks++;
    if (ob[KS] !== 1'b1 || ob[kret-1] !== 1'b1 || ob[kret] !== 1'b0) begin
      errors++;
      $display("FAIL ferr_busy: got %b%b%b want 110",
               ob[KS], ob[kret-1], ob[kret]);
    end
    checks++;
    if (od[kret] !== model_dout) begin
      errors++;
      $display("FAIL ferr_dout: got %0h want %0h", od[kret], model_dout);
    end
  endtask

  task automatic test_back_to_back;
    int t1;
    t1 = STOP0 + H + 1;
    make_frame(8'h55, 1'b0, 1'b1, H + 1, 0);
    make_frame(8'hF0, 1'b0, 1'b1, BC, 2);
    play(-1);
    checks++;
    if (ov[KS] !== 1'b1 || od[KS] !== 8'h55) begin
      errors++;
      $display("FAIL b2b_first: got v=%b d=%0h want v=1 d=55", ov[KS], od[KS]);
    end
    checks++;
    if (ob[KS] !== 1'b0 || ob[KS+1] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy: got %b%b want 01", ob[KS], ob[KS+1]);
    end
    checks++;
    if (ov[t1+KS] !== 1'b1 || od[t1+KS] !== 8'hF0) begin
      errors++;
      $display("FAIL b2b_second: got v=%b d=%0h want v=1 d=f0",
               ov[t1+KS], od[t1+KS]);
    end
    checks++;
    if (nstrobe(1, 0, 0) !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 2", nstrobe(1, 0, 0));
    end
    model_dout = 8'hF0;
  endtask

  task automatic test_reset_midframe;
    make_frame(8'h5A, 1'b0, 1'b1, BC, 2);
    play(H + 4 * BC + 2);
    RESET = 1'b1;
    #1;
    checks++;
    if (bus.DOUT !== '0 || bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_out: got d=%0h b=%b want d=0 b=0",
               bus.DOUT, bus.BUSY);
    end
    checks++;
    if (bus.VALID !== 1'b0 || bus.FERR !== 1'b0 || bus.PERR !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_strobes: got %b%b%b want 000",
               bus.VALID, bus.FERR, bus.PERR);
    end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_dout = '0;
    repeat (4) line.push_back(1'b1);
    make_frame(8'h12, 1'b0, 1'b1, BC, 2);
    play(-1);
    checks++;
    if (nstrobe(1, 1, 1) !== 1 || ov[4+KS] !== 1'b1) begin
      errors++;
      $display("FAIL mid_new_valid: got n=%0d v=%b want n=1 v=1",
               nstrobe(1, 1, 1), ov[4+KS]);
    end
    checks++;
    if (od[3] !== 8'h00 || od[4+KS] !== 8'h12) begin
      errors++;
      $display("FAIL mid_new_dout: got %0h,%0h want 0,12", od[3], od[4+KS]);
    end
    model_dout = 8'h12;
  endtask

  task automatic test_random;
    logic [DW-1:0] d;
    bit stopbit, bad, good;
    int sl, tail, nexp;
    for (int r = 0; r < 10; r++) begin
      d       = DW'($urandom);
      stopbit = ($urandom_range(0, 3) != 0);
      bad     = (P == 1) && ($urandom_range(0, 2) == 0);
      sl      = stopbit ? $urandom_range(H + 1, BC) : $urandom_range(H + 1, BC + 6);
      tail    = $urandom_range(1, 3);
      good    = stopbit && !bad;
      nexp    = int'(good) + int'(!stopbit) + int'(bad);
      make_frame(d, bad, stopbit, sl, tail);
      play(-1);
      checks++;
      if (ov[KS] !== good || of[KS] !== !stopbit || op[KS] !== bad) begin
        errors++;
        $display("FAIL rnd%0d_flags: got v%b f%b p%b want v%b f%b p%b",
                 r, ov[KS], of[KS], op[KS], good, !stopbit, bad);
      end
      if (good) model_dout = d;
      checks++;
      if (od[KS] !== model_dout) begin
        errors++;
        $display("FAIL rnd%0d_dout: got %0h want %0h", r, od[KS], model_dout);
      end
      checks++;
      if (nstrobe(1, 1, 1) !== nexp) begin
        errors++;
        $display("FAIL rnd%0d_count: got %0d want %0d",
                 r, nstrobe(1, 1, 1), nexp);
      end
      checks++;
      if (ob[KS] !== !stopbit || ob[STOP0+sl] !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_busy: got %b%b want %b0",
                 r, ob[KS], ob[STOP0+sl], !stopbit);
      end
    end
  endtask

  initial begin
    bus.SIN = 1'b1;
    test_reset();
    test_good_frame(8'hA5);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    test_parity();
`endif
    test_false_start();
    test_framing();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
